// File: rtl/fht_input_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fht_input_loader_pkg
// Description : Shared types, constants and helpers for the FHT input loader.
// Revision    : 1.0 - initial release
// ============================================================================
package fht_input_loader_pkg;

    // Default geometry: bank address width and resulting frame length
    localparam int DEF_A_BIT = 8;
    localparam int N_PTS     = 2 ** (DEF_A_BIT + 2);

    // Loader sequencing states
    typedef enum logic [2:0] {
        ST_LOAD  = 3'd0,
        ST_FLUSH = 3'd1,
        ST_START = 3'd2,
        ST_ACK   = 3'd3,
        ST_RUN   = 3'd4
    } state_t;

    // Reverse the low 'width' bits of 'val'; bits above 'width' come back zero
    function automatic logic [31:0] bitrev(input logic [31:0] val, input int width);
        logic [31:0] res;
        res = '0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                res[width-1-i] = val[i];
            end
        end
        return res;
    endfunction

endpackage : fht_input_loader_pkg
`default_nettype wire

// File: rtl/fht_input_loader_if.sv
`default_nettype none
// ============================================================================
// Module      : fht_input_loader_if
// Description : Sample-stream handshake, FHT control and bank-write bundle.
// Revision    : 1.0 - initial release
// ============================================================================
interface fht_input_loader_if #(
    parameter int A_BIT = 8,
    parameter int D_BIT = 16
);
    logic             valid;    // input sample valid
    logic [D_BIT-1:0] data;     // input sample
    logic             ready;    // loader accepts a sample this cycle
    logic             fht_rdy;  // fht_control idle/done
    logic             start;    // one-cycle start pulse to fht_control
    logic [A_BIT-1:0] addr_wr;  // bank write address
    logic [D_BIT-1:0] data_wr;  // bank write data
    logic [3:0]       we;       // one-hot bank write enable [bank3..bank0]
    logic             busy;     // frame in progress or transform running
    logic             err;      // sticky start-acknowledge timeout

    // Environment side: sample source plus FHT status
    modport master (
        output valid, data, fht_rdy,
        input  ready, start, addr_wr, data_wr, we, busy, err
    );

    // Loader side
    modport slave (
        input  valid, data, fht_rdy,
        output ready, start, addr_wr, data_wr, we, busy, err
    );
endinterface : fht_input_loader_if
`default_nettype wire

// File: rtl/fht_input_loader_bitrev.sv
`default_nettype none
// ============================================================================
// Module      : fht_bitrev
// Description : Combinational bit-order reversal of a WIDTH-bit index.
// Revision    : 1.0 - initial release
// ============================================================================
module fht_bitrev #(
    parameter int WIDTH = 10
) (
    input  wire logic [WIDTH-1:0] i_val,
    output logic      [WIDTH-1:0] o_val
);
    // Pure wiring: output bit i takes input bit WIDTH-1-i
    for (genvar i = 0; i < WIDTH; i++) begin : g_rev
        assign o_val[i] = i_val[WIDTH-1-i];
    end
endmodule : fht_bitrev
`default_nettype wire

// File: rtl/fht_input_loader.sv
`default_nettype none
// ============================================================================
// Module      : fht_input_loader
// Description : Loads one frame of samples into the four FHT data banks in
//               bit-reversed order, then starts the transform and waits for
//               it to finish before accepting the next frame.
// Revision    : 1.0 - initial release
// ============================================================================
module fht_input_loader
    import fht_input_loader_pkg::*;
#(
    parameter int A_BIT  = 8,
    parameter int D_BIT  = 16,
    parameter int ACK_TO = 16
) (
    input  wire logic          clk,
    input  wire logic          rst,
    fht_input_loader_if.slave  bus
);
    localparam int                c_IDX_W   = A_BIT + 2;
    localparam logic [c_IDX_W-1:0] c_LAST   = '1;
    localparam int                c_TO_W    = $clog2(ACK_TO + 1);
    localparam logic [c_TO_W-1:0] c_TO_LAST = c_TO_W'(ACK_TO - 1);

    state_t              r_state;
    logic [c_IDX_W-1:0]  r_cnt;
    logic [c_TO_W-1:0]   r_tcnt;
    logic [3:0]          r_we;
    logic [A_BIT-1:0]    r_addr;
    logic [D_BIT-1:0]    r_data;
    logic                r_err;

    logic [c_IDX_W-1:0]  w_rev;
    logic                w_ready;
    logic                w_accept;

    // Bit-reversed frame index: low two bits pick the bank, the rest the address
    fht_bitrev #(.WIDTH(c_IDX_W)) u_bitrev (
        .i_val (r_cnt),
        .o_val (w_rev)
    );

    // Samples are taken only while loading; held low during the reset cycle
    assign w_ready  = (r_state == ST_LOAD) && !rst;
    assign w_accept = bus.valid && w_ready;

    // Sequencing, sample/timeout counters and registered bank-write port
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOAD;
            r_cnt   <= '0;
            r_tcnt  <= '0;
            r_we    <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_err   <= 1'b0;
        end else begin
            r_we <= '0;
            if (w_accept) begin
                r_we   <= 4'b0001 << w_rev[1:0];
                r_addr <= w_rev[c_IDX_W-1:2];
                r_data <= bus.data;
                r_cnt  <= r_cnt + c_IDX_W'(1);
            end

            case (r_state)
                ST_LOAD: begin
                    // Counter wraps to zero on the final sample of the frame
                    if (w_accept && (r_cnt == c_LAST)) begin
                        r_state <= ST_FLUSH;
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_START;
                end
                ST_START: begin
                    // Pulse goes out only while the FHT reports idle
                    r_tcnt <= '0;
                    if (bus.fht_rdy) begin
                        r_state <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    if (!bus.fht_rdy) begin
                        r_state <= ST_RUN;
                        r_tcnt  <= '0;
                    end else if (r_tcnt == c_TO_LAST) begin
                        r_err   <= 1'b1;
                        r_state <= ST_LOAD;
                        r_cnt   <= '0;
                        r_tcnt  <= '0;
                    end else begin
                        r_tcnt <= r_tcnt + c_TO_W'(1);
                    end
                end
                ST_RUN: begin
                    if (bus.fht_rdy) begin
                        r_state <= ST_LOAD;
                    end
                end
                default: begin
                    r_state <= ST_LOAD;
                end
            endcase
        end
    end

    assign bus.ready   = w_ready;
    assign bus.start   = (r_state == ST_START) && bus.fht_rdy;
    assign bus.we      = r_we;
    assign bus.addr_wr = r_addr;
    assign bus.data_wr = r_data;
    assign bus.err     = r_err;
    assign bus.busy    = (r_state != ST_LOAD) || (r_cnt != '0) || w_accept;

endmodule : fht_input_loader
`default_nettype wire

// File: tb/tb_fht_input_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_fht_input_loader
// Description : Self-checking bench for fht_input_loader with a frame-level
//               reference model of the bit-reversed bank mapping.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fht_input_loader;
    localparam int A_BIT  = 8;
    localparam int D_BIT  = 16;
    localparam int ACK_TO = 16;
    localparam int N      = 1024;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    fht_input_loader_if #(.A_BIT(A_BIT), .D_BIT(D_BIT)) bus ();

    fht_input_loader #(.A_BIT(A_BIT), .D_BIT(D_BIT), .ACK_TO(ACK_TO)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors     = 0;
    int miscompares = 0;
    int frame_no    = 0;

    logic [15:0] exp_data  [N];
    int          obs_loc   [N];
    int          obs_frame [N];
    logic [15:0] mem       [N];
    int          mem_frame [N];

    int          lat_err   = 0;
    int          start_cnt = 0;
    int          m_idx     = 0;
    int          prev_idx  = 0;
    bit          prev_acc  = 0;
    logic [15:0] prev_data = '0;
    int          mon_loc;
    int          mon_bank;

    // Reference location of frame index idx: reverse 10 bits, bank = low 2, addr = upper 8
    function automatic int model_loc(input int idx);
        int r = 0;
        for (int b = 0; b < 10; b++) begin
            if (((idx >> b) & 1) == 1) r += 1 << (9 - b);
        end
        return (r % 4) * 256 + r / 4;
    endfunction

    function automatic int frame_errors(input int n);
        int bad = 0;
        int loc;
        for (int i = 0; i < n; i++) begin
            loc = model_loc(i);
            if (obs_frame[i] != frame_no || obs_loc[i] != loc ||
                mem_frame[loc] != frame_no || mem[loc] !== exp_data[i]) bad++;
        end
        return bad;
    endfunction

    function automatic int distinct_locs();
        bit used [N];
        int cnt = 0;
        for (int i = 0; i < N; i++) used[i] = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (obs_frame[i] == frame_no && obs_loc[i] >= 0 && obs_loc[i] < N) begin
                if (!used[obs_loc[i]]) cnt++;
                used[obs_loc[i]] = 1'b1;
            end
        end
        return cnt;
    endfunction

    // Write monitor: every accept must produce exactly its write one cycle later
    always @(negedge clk) begin
        if (rst) begin
            m_idx    <= 0;
            prev_acc <= 1'b0;
        end else begin
            case (bus.we)
                4'b0001: mon_bank = 0;
                4'b0010: mon_bank = 1;
                4'b0100: mon_bank = 2;
                4'b1000: mon_bank = 3;
                default: mon_bank = -1;
            endcase
            if (prev_acc) begin
                mon_loc = model_loc(prev_idx);
                if (bus.we !== (4'b0001 << (mon_loc / 256)) ||
                    bus.addr_wr !== 8'(mon_loc % 256) || bus.data_wr !== prev_data)
                    lat_err <= lat_err + 1;
                if (mon_bank >= 0) begin
                    obs_loc[prev_idx]   <= mon_bank * 256 + int'(bus.addr_wr);
                    obs_frame[prev_idx] <= frame_no;
                    mem[mon_bank * 256 + int'(bus.addr_wr)]       <= bus.data_wr;
                    mem_frame[mon_bank * 256 + int'(bus.addr_wr)] <= frame_no;
                end
            end else if (bus.we !== 4'b0000) begin
                lat_err <= lat_err + 1;
            end
            prev_acc  <= (bus.valid === 1'b1 && bus.ready === 1'b1);
            prev_idx  <= m_idx;
            prev_data <= bus.data;
            if (bus.valid === 1'b1 && bus.ready === 1'b1) m_idx <= (m_idx + 1) % N;
        end
        if (bus.start === 1'b1) begin
            start_cnt <= start_cnt + 1;
            if (bus.fht_rdy !== 1'b1) lat_err <= lat_err + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Feed n_acc accepted samples; returns in the cycle after the last accept
    task automatic stream_frame(input int gap_pct, input int n_acc, input bit toggle_rdy,
                                output bit ok);
        int acc = 0;
        int cyc = 0;
        frame_no++;
        while (acc < n_acc && cyc < 40 * N) begin
            bus.valid = (int'($urandom_range(99)) >= gap_pct);
            bus.data  = 16'($urandom);
            if (toggle_rdy) bus.fht_rdy = 1'($urandom_range(1));
            @(negedge clk);
            if (bus.valid === 1'b1 && bus.ready === 1'b1) begin
                exp_data[acc] = bus.data;
                acc++;
            end
            tick();
            cyc++;
        end
        bus.valid = 1'b0;
        ok = (acc == n_acc);
    endtask

    // Plays a well-behaved FHT from the FLUSH cycle until the loader reopens
    task automatic run_fht(output bit ok);
        int cyc = 0;
        ok = 1'b0;
        bus.fht_rdy = 1'b1;
        while (cyc < 50) begin
            @(negedge clk);
            if (bus.start === 1'b1) break;
            tick();
            cyc++;
        end
        tick();
        bus.fht_rdy = 1'b0;
        repeat (3) tick();
        bus.fht_rdy = 1'b1;
        cyc = 0;
        while (cyc < 50) begin
            @(negedge clk);
            if (bus.ready === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
            cyc++;
        end
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.valid = 1'b0;
        repeat (2) tick();
        @(negedge clk);
        vectors++; if (bus.ready !== 1'b0) begin miscompares++; $display("FAIL reset_ready: got %0b want 0", bus.ready); end
        vectors++; if (bus.we !== 4'b0000) begin miscompares++; $display("FAIL reset_we: got %b want 0000", bus.we); end
        vectors++; if (bus.addr_wr !== 8'h00 || bus.data_wr !== 16'h0000) begin miscompares++; $display("FAIL reset_wr: got addr %0h data %0h want 0 0", bus.addr_wr, bus.data_wr); end
        vectors++; if (bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.start !== 1'b0) begin miscompares++; $display("FAIL reset_flags: got busy %0b err %0b start %0b want 0 0 0", bus.busy, bus.err, bus.start); end
        tick();
        rst = 1'b0;
        @(negedge clk);
        vectors++; if (bus.ready !== 1'b1) begin miscompares++; $display("FAIL ready_after_reset: got %0b want 1", bus.ready); end
        tick();
    endtask

    task automatic test_stream();
        bit ok;
        stream_frame(0, N, 1'b0, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL stream_full: got %0b want 1 (frame not accepted in budget)", ok); end
    endtask

    task automatic test_handshake();
        bit saw_ready = 1'b0;
        int s0 = start_cnt;
        @(negedge clk);
        vectors++; if (bus.ready !== 1'b0 || bus.start !== 1'b0 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL flush_cycle: got ready %0b start %0b busy %0b want 0 0 1", bus.ready, bus.start, bus.busy); end
        tick();
        @(negedge clk);
        vectors++; if (bus.start !== 1'b1) begin miscompares++; $display("FAIL start_pulse: got %0b want 1", bus.start); end
        tick();
        @(negedge clk);
        vectors++; if (bus.start !== 1'b0 || bus.ready !== 1'b0) begin miscompares++; $display("FAIL start_one_cycle: got start %0b ready %0b want 0 0", bus.start, bus.ready); end
        tick();
        tick();
        bus.fht_rdy = 1'b0;
        repeat (10) begin
            tick();
            @(negedge clk);
            if (bus.ready !== 1'b0) saw_ready = 1'b1;
        end
        vectors++; if (saw_ready !== 1'b0) begin miscompares++; $display("FAIL ready_during_run: got %0b want 0", saw_ready); end
        tick();
        bus.fht_rdy = 1'b1;
        @(negedge clk);
        vectors++; if (bus.ready !== 1'b0 || bus.busy !== 1'b1) begin miscompares++; $display("FAIL done_edge: got ready %0b busy %0b want 0 1", bus.ready, bus.busy); end
        tick();
        @(negedge clk);
        vectors++; if (bus.ready !== 1'b1 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL reopen: got ready %0b busy %0b want 1 0", bus.ready, bus.busy); end
        vectors++; if (start_cnt - s0 !== 1) begin miscompares++; $display("FAIL start_count: got %0d want 1", start_cnt - s0); end
        tick();
    endtask

    task automatic test_mapping();
        vectors++; if (obs_loc[1] !== 128 || obs_frame[1] !== frame_no) begin miscompares++; $display("FAIL map_idx1: got loc %0d want 128", obs_loc[1]); end
        vectors++; if (obs_loc[2] !== 64) begin miscompares++; $display("FAIL map_idx2: got loc %0d want 64", obs_loc[2]); end
        vectors++; if (obs_loc[256] !== 512) begin miscompares++; $display("FAIL map_idx256: got loc %0d want 512", obs_loc[256]); end
        vectors++; if (obs_loc[512] !== 256) begin miscompares++; $display("FAIL map_idx512: got loc %0d want 256", obs_loc[512]); end
        vectors++; if (obs_loc[1023] !== 1023) begin miscompares++; $display("FAIL map_idx1023: got loc %0d want 1023", obs_loc[1023]); end
        vectors++; if (distinct_locs() !== N) begin miscompares++; $display("FAIL map_unique: got %0d want %0d", distinct_locs(), N); end
        vectors++; if (frame_errors(N) !== 0) begin miscompares++; $display("FAIL map_contents: got %0d bad entries want 0", frame_errors(N)); end
        vectors++; if (lat_err !== 0) begin miscompares++; $display("FAIL write_timing: got %0d violations want 0", lat_err); end
    endtask

    task automatic test_gaps();
        bit ok, ok2;
        stream_frame(50, N, 1'b0, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL gaps_stream: got %0b want 1", ok); end
        run_fht(ok2);
        vectors++; if (ok2 !== 1'b1) begin miscompares++; $display("FAIL gaps_fht: got %0b want 1", ok2); end
        vectors++; if (frame_errors(N) !== 0) begin miscompares++; $display("FAIL gaps_contents: got %0d bad entries want 0", frame_errors(N)); end
        vectors++; if (lat_err !== 0) begin miscompares++; $display("FAIL gaps_timing: got %0d violations want 0", lat_err); end
    endtask

    task automatic test_timeout();
        bit ok;
        bit early = 1'b0;
        bus.fht_rdy = 1'b1;
        stream_frame(0, N, 1'b0, ok);
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL to_stream: got %0b want 1", ok); end
        @(negedge clk);
        tick();
        @(negedge clk);
        vectors++; if (bus.start !== 1'b1) begin miscompares++; $display("FAIL to_start: got %0b want 1", bus.start); end
        for (int k = 0; k < ACK_TO; k++) begin
            tick();
            @(negedge clk);
            if (bus.err !== 1'b0) early = 1'b1;
        end
        vectors++; if (early !== 1'b0) begin miscompares++; $display("FAIL to_early: got %0b want 0", early); end
        tick();
        @(negedge clk);
        vectors++; if (bus.err !== 1'b1 || bus.ready !== 1'b1 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL to_err: got err %0b ready %0b busy %0b want 1 1 0", bus.err, bus.ready, bus.busy); end
        tick();
        stream_frame(0, 500, 1'b0, ok);
        @(negedge clk);
        vectors++; if (ok !== 1'b1 || obs_frame[0] !== frame_no || obs_loc[0] !== 0) begin miscompares++; $display("FAIL to_next_idx0: got ok %0b loc %0d want 1 0", ok, obs_loc[0]); end
        vectors++; if (bus.err !== 1'b1) begin miscompares++; $display("FAIL to_err_sticky: got %0b want 1", bus.err); end
        tick();
    endtask

    task automatic test_reset_midframe();
        bit ok, ok2;
        int s0 = start_cnt;
        rst = 1'b1;
        bus.valid = 1'b1;
        tick();
        bus.valid = 1'b0;
        @(negedge clk);
        vectors++; if (bus.ready !== 1'b0 || bus.we !== 4'b0000 || bus.busy !== 1'b0 || bus.err !== 1'b0 || bus.start !== 1'b0 || bus.addr_wr !== 8'h00 || bus.data_wr !== 16'h0000) begin miscompares++; $display("FAIL mid_reset: got ready %0b we %b busy %0b err %0b start %0b want 0 0000 0 0 0", bus.ready, bus.we, bus.busy, bus.err, bus.start); end
        tick();
        rst = 1'b0;
        repeat (3) tick();
        @(negedge clk);
        vectors++; if (start_cnt - s0 !== 0 || bus.ready !== 1'b1 || bus.busy !== 1'b0) begin miscompares++; $display("FAIL mid_no_start: got starts %0d ready %0b busy %0b want 0 1 0", start_cnt - s0, bus.ready, bus.busy); end
        tick();
        stream_frame(25, N, 1'b0, ok);
        run_fht(ok2);
        vectors++; if (ok !== 1'b1 || ok2 !== 1'b1) begin miscompares++; $display("FAIL mid_frame_run: got %0b%0b want 11", ok, ok2); end
        vectors++; if (frame_errors(N) !== 0 || obs_loc[0] !== 0) begin miscompares++; $display("FAIL mid_contents: got %0d bad entries idx0 loc %0d want 0 0", frame_errors(N), obs_loc[0]); end
    endtask

    task automatic test_start_hold();
        bit ok;
        bit premature = 1'b0;
        int s0 = start_cnt;
        stream_frame(10, N, 1'b1, ok);
        bus.fht_rdy = 1'b0;
        vectors++; if (ok !== 1'b1) begin miscompares++; $display("FAIL hold_stream: got %0b want 1", ok); end
        @(negedge clk);
        repeat (6) begin
            tick();
            @(negedge clk);
            if (bus.start !== 1'b0 || bus.ready !== 1'b0) premature = 1'b1;
        end
        vectors++; if (premature !== 1'b0) begin miscompares++; $display("FAIL hold_withheld: got %0b want 0", premature); end
        tick();
        bus.fht_rdy = 1'b1;
        @(negedge clk);
        vectors++; if (bus.start !== 1'b1) begin miscompares++; $display("FAIL hold_release: got %0b want 1", bus.start); end
        tick();
        @(negedge clk);
        vectors++; if (bus.start !== 1'b0) begin miscompares++; $display("FAIL hold_one_cycle: got %0b want 0", bus.start); end
        bus.fht_rdy = 1'b0;
        repeat (2) tick();
        bus.fht_rdy = 1'b1;
        tick();
        @(negedge clk);
        vectors++; if (bus.ready !== 1'b1) begin miscompares++; $display("FAIL hold_reopen: got %0b want 1", bus.ready); end
        vectors++; if (start_cnt - s0 !== 1) begin miscompares++; $display("FAIL hold_start_count: got %0d want 1", start_cnt - s0); end
        vectors++; if (frame_errors(N) !== 0 || lat_err !== 0) begin miscompares++; $display("FAIL hold_contents: got %0d bad entries %0d timing want 0 0", frame_errors(N), lat_err); end
        tick();
    endtask

    initial begin
        bus.valid   = 1'b0;
        bus.data    = '0;
        bus.fht_rdy = 1'b1;
        for (int i = 0; i < N; i++) begin
            obs_loc[i]   = -1;
            obs_frame[i] = 0;
            mem_frame[i] = 0;
            mem[i]       = '0;
        end
        test_reset();
        test_stream();
        test_handshake();
        test_mapping();
        test_gaps();
        test_timeout();
        test_reset_midframe();
        test_start_hold();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end
endmodule : tb_fht_input_loader
`default_nettype wire
